// File: rtl/f_le_serial_fsm.sv
// f_le_serial_fsm: multi-cycle IEEE-754 a <= b comparator that flags NaN operands.
// Ports: clk, rst_n (async, active-low); valid_in/a/b request, accepted only when idle;
// busy high while a request is in flight; valid_out one-cycle strobe with res (a <= b)
// and err (a or b is NaN), both held until the next result or reset.
// Magnitudes are compared CHUNK bits per cycle, MSB slice first.
// Build option F_LE_SERIAL_EARLY_EXIT_EN: finish as soon as the result is decided.
module f_le_serial_fsm #(
  parameter int FLEN  = 64,
  parameter int NE    = 11,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            busy,
  output logic            valid_out,
  output logic            res,
  output logic            err
);
  localparam int NF     = FLEN - 1 - NE;
  localparam int NSLICE = FLEN / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_n;
  logic [FLEN-1:0] ma, mb;
  logic [IW-1:0] idx;
  logic nan, sa, sb, bz, lt, gt;
  logic lt_n, gt_n, res_n, last, flag_dec;
  logic [CHUNK-1:0] sl_a, sl_b;
  logic nan_in, bz_in;
  assign nan_in = (&a[FLEN-2 -: NE] && |a[NF-1:0]) || (&b[FLEN-2 -: NE] && |b[NF-1:0]);
  assign bz_in  = ~|a[FLEN-2:0] && ~|b[FLEN-2:0];
  assign busy      = state != IDLE;
  assign valid_out = state == DONE;
  always_comb begin
    sl_a     = ma[FLEN-1-int'(idx)*CHUNK -: CHUNK];
    sl_b     = mb[FLEN-1-int'(idx)*CHUNK -: CHUNK];
    // only the first differing slice may set a flag; later slices are ignored
    lt_n     = lt | (~gt & (sl_a < sl_b));
    gt_n     = gt | (~lt & (sl_a > sl_b));
    last     = idx == IW'(NSLICE - 1);
    flag_dec = nan | bz | (sa ^ sb);
    res_n    = nan ? 1'b0 : bz ? 1'b1 : (sa ^ sb) ? sa : sa ? ~lt_n : ~gt_n;
    state_n  = state;
    case (state)
      IDLE: state_n = valid_in ? CMP : IDLE;
`ifdef F_LE_SERIAL_EARLY_EXIT_EN
      CMP:  state_n = (last || flag_dec || sl_a != sl_b) ? DONE : CMP;
`else
      CMP:  state_n = last ? DONE : CMP;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      ma    <= '0;
      mb    <= '0;
      nan   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      res   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && valid_in) begin
        ma  <= {1'b0, a[FLEN-2:0]};
        mb  <= {1'b0, b[FLEN-2:0]};
        nan <= nan_in;
        sa  <= a[FLEN-1];
        sb  <= b[FLEN-1];
        bz  <= bz_in;
        lt  <= 1'b0;
        gt  <= 1'b0;
        idx <= '0;
      end else if (state == CMP) begin
        idx <= idx + 1'b1;
        lt  <= lt_n;
        gt  <= gt_n;
        if (state_n == DONE) begin
          res <= res_n;
          err <= nan;
        end
      end
    end
  end
endmodule
